// File: rtl/ascon_fsm_pkg.sv
// Shared types and constants for the ASCON control FSM: state encoding, conf_xor_down codes,
// default round counts and the round-counter start helper.
package ascon_fsm_pkg;

  localparam int unsigned DefRoundsA = 12;
  localparam int unsigned DefRoundsB = 6;

  localparam logic [1:0] ConfKeyInit = 2'b00;
  localparam logic [1:0] ConfDomSep  = 2'b01;
  localparam logic [1:0] ConfKeyPre  = 2'b10;
  localparam logic [1:0] ConfKeyPost = 2'b11;

  localparam logic [3:0] LastRound = 4'd11;

  typedef enum logic [3:0] {
    StIdle, StLoad, StInitP, StInitEnd,
    StAdWait, StAdXor, StAdP, StAdEnd,
    StPtWait, StPtXor, StPtP, StFinP,
    StTag, StDone
  } state_e;

  // A p^R phase runs round constants 12-R .. 11.
  function automatic logic [3:0] round_start(input int unsigned rounds);
    return 4'(12 - rounds);
  endfunction

endpackage

// File: rtl/ascon_round_cnt.sv
// Loadable 4-bit round-constant counter; last is high while the final round (11) is active.
module ascon_round_cnt
  import ascon_fsm_pkg::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       enable,
  output logic [3:0] round,
  output logic       last
);

  logic [3:0] cnt_q;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (enable) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign round = cnt_q;
  assign last  = (cnt_q == LastRound);

endmodule

// File: rtl/ascon_fsm_param.sv
// ASCON AEAD control FSM sequencing init, AD, plaintext, finalisation and tag phases.
// Optional decrypt mode is enabled by defining ASCON_DECRYPT_EN.
module ascon_fsm_param
  import ascon_fsm_pkg::*;
#(
  parameter int unsigned ROUNDS_A = DefRoundsA,
  parameter int unsigned ROUNDS_B = DefRoundsB,
  parameter int unsigned BLK_W    = 8
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic             data_valid_i,
  input  logic [BLK_W-1:0] nb_ad_i,
  input  logic [BLK_W-1:0] nb_pt_i,
`ifdef ASCON_DECRYPT_EN
  input  logic             decrypt_i,
  output logic             dec_mode_o,
`endif
  output logic             data_ready_o,
  output logic             init_state_o,
  output logic             ena_reg_state_o,
  output logic             ena_xor_up_o,
  output logic             ena_xor_down_o,
  output logic [1:0]       conf_xor_down_o,
  output logic [3:0]       round_o,
  output logic             cipher_valid_o,
  output logic             tag_valid_o,
  output logic             end_o,
  output logic             busy_o
);

  localparam logic [3:0] StartA = round_start(ROUNDS_A);
  localparam logic [3:0] StartB = round_start(ROUNDS_B);

  state_e           state_q, state_d;
  logic [BLK_W-1:0] nb_ad_q, nb_pt_q, blk_cnt_q;
  logic             rnd_load, rnd_en, rnd_last;
  logic [3:0]       rnd_val, rnd_cnt;
  logic             pt_last;

  ascon_round_cnt u_round_cnt (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .load     (rnd_load),
    .load_val (rnd_val),
    .enable   (rnd_en),
    .round    (rnd_cnt),
    .last     (rnd_last)
  );

  // Counter still holds the pre-increment index during PT_XOR.
  assign pt_last = (blk_cnt_q == nb_pt_q - BLK_W'(1));

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      nb_ad_q   <= '0;
      nb_pt_q   <= '0;
      blk_cnt_q <= '0;
    end else if (state_q == StLoad) begin
      nb_ad_q   <= nb_ad_i;
      nb_pt_q   <= (nb_pt_i == '0) ? BLK_W'(1) : nb_pt_i;
      blk_cnt_q <= '0;
    end else if (state_q == StAdEnd) begin
      blk_cnt_q <= '0;
    end else if (state_q == StAdXor || state_q == StPtXor) begin
      blk_cnt_q <= blk_cnt_q + BLK_W'(1);
    end
  end

`ifdef ASCON_DECRYPT_EN
  logic dec_mode_q;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      dec_mode_q <= 1'b0;
    end else if (state_q == StLoad) begin
      dec_mode_q <= decrypt_i;
    end else if (state_q == StDone) begin
      dec_mode_q <= 1'b0;
    end
  end

  assign dec_mode_o = dec_mode_q;
`endif

  always_comb begin
    state_d         = state_q;
    data_ready_o    = 1'b0;
    init_state_o    = 1'b0;
    ena_reg_state_o = 1'b0;
    ena_xor_up_o    = 1'b0;
    ena_xor_down_o  = 1'b0;
    conf_xor_down_o = ConfKeyInit;
    round_o         = 4'd0;
    cipher_valid_o  = 1'b0;
    tag_valid_o     = 1'b0;
    end_o           = 1'b0;
    rnd_load        = 1'b0;
    rnd_val         = StartA;
    rnd_en          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StLoad;
      end
      StLoad: begin
        init_state_o    = 1'b1;
        ena_reg_state_o = 1'b1;
        rnd_load        = 1'b1;
        rnd_val         = StartA;
        state_d         = StInitP;
      end
      StInitP, StAdP, StPtP, StFinP: begin
        ena_reg_state_o = 1'b1;
        rnd_en          = 1'b1;
        round_o         = rnd_cnt;
        if (rnd_last) begin
          unique case (state_q)
            StInitP: state_d = StInitEnd;
            StAdP:   state_d = (blk_cnt_q == nb_ad_q) ? StAdEnd : StAdWait;
            StPtP:   state_d = StPtWait;
            default: state_d = StTag;
          endcase
        end
      end
      StInitEnd: begin
        ena_xor_down_o  = 1'b1;
        conf_xor_down_o = ConfKeyInit;
        state_d         = (nb_ad_q != '0) ? StAdWait : StAdEnd;
      end
      StAdWait: begin
        data_ready_o = 1'b1;
        if (data_valid_i) state_d = StAdXor;
      end
      StAdXor: begin
        ena_xor_up_o = 1'b1;
        rnd_load     = 1'b1;
        rnd_val      = StartB;
        state_d      = StAdP;
      end
      StAdEnd: begin
        ena_xor_down_o  = 1'b1;
        conf_xor_down_o = ConfDomSep;
        state_d         = StPtWait;
      end
      StPtWait: begin
        data_ready_o = 1'b1;
        if (data_valid_i) state_d = StPtXor;
      end
      StPtXor: begin
        ena_xor_up_o   = 1'b1;
        cipher_valid_o = 1'b1;
        rnd_load       = 1'b1;
        if (pt_last) begin
          ena_xor_down_o  = 1'b1;
          conf_xor_down_o = ConfKeyPre;
          rnd_val         = StartA;
          state_d         = StFinP;
        end else begin
          rnd_val = StartB;
          state_d = StPtP;
        end
      end
      StTag: begin
        ena_xor_down_o  = 1'b1;
        conf_xor_down_o = ConfKeyPost;
        tag_valid_o     = 1'b1;
        state_d         = StDone;
      end
      StDone: begin
        end_o   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q != StIdle);

endmodule
